// File: rtl/adc_par_reader.sv
// ---------------------------------------------------------------------------------------------
// adc_par_reader
//   Read side of the 8-bit parallel ADC/DAC lab. Periodically starts a conversion on an 8-bit
//   parallel ADC (CONVSTn/CSn/RDn/BUSY handshake), waits for BUSY to drop, reads the bus and
//   presents the result as a one-cycle valid strobe plus an LED mirror.
//
//   Optional feature macro: ADC_AVG_EN
//     defined   : output is the truncated mean of the last four captured samples
//                 (history starts zero-filled, so the first three results ramp up)
//     undefined : output is the raw captured sample, no history logic is built
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous, active-low reset
//   adc_busy      in   ADC BUSY, active-high during conversion, asynchronous to clk
//   adc_d         in   ADC parallel data bus [7:0]
//   adc_convstn   out  conversion start, active-low
//   adc_csn       out  chip select, active-low
//   adc_rdn       out  read strobe, active-low
//   sample_data   out  last accepted sample [7:0]
//   sample_valid  out  one-cycle pulse when sample_data updates
//   led_out       out  copy of sample_data [7:0]
//   timeout_err   out  sticky: BUSY never dropped within BUSY_TIMEOUT cycles
//
// All timing parameters must lie in 1..1023 (10-bit phase counter).
// ---------------------------------------------------------------------------------------------
module adc_par_reader #(
   parameter int unsigned GAP_CYC      = 200,
   parameter int unsigned CONV_CYC     = 20,
   parameter int unsigned RD_CYC       = 30,
   parameter int unsigned BUSY_MIN     = 4,
   parameter int unsigned BUSY_TIMEOUT = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       adc_busy,
   input  logic [7:0] adc_d,
   output logic       adc_convstn,
   output logic       adc_csn,
   output logic       adc_rdn,
   output logic [7:0] sample_data,
   output logic       sample_valid,
   output logic [7:0] led_out,
   output logic       timeout_err
);

   localparam logic [9:0] GapLast     = 10'(GAP_CYC - 1);
   localparam logic [9:0] ConvLast    = 10'(CONV_CYC - 1);
   localparam logic [9:0] RdLast      = 10'(RD_CYC - 1);
   localparam logic [9:0] BusyMinLast = 10'(BUSY_MIN - 1);
   localparam logic [9:0] TimeoutLast = 10'(BUSY_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StGap,
      StConvst,
      StWaitBusy,
      StRead,
      StDone
   } state_e;

   state_e     state;
   logic [9:0] cnt;
   logic       busy_meta;
   logic       busy_s;
   logic       capture;
   logic [7:0] result;

   // BUSY is asynchronous; reset to "busy" so nothing is read before the sync settles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_meta <= 1'b1;
         busy_s    <= 1'b1;
      end else begin
         busy_meta <= adc_busy;
         busy_s    <= busy_meta;
      end
   end

   // Data is sampled on the last RDn-low edge
   assign capture = (state == StRead) && (cnt == RdLast);

`ifdef ADC_AVG_EN
   logic [7:0] h0, h1, h2, h3;
   logic [9:0] sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h0 <= 8'h00;
         h1 <= 8'h00;
         h2 <= 8'h00;
         h3 <= 8'h00;
      end else if (capture) begin
         h0 <= adc_d;
         h1 <= h0;
         h2 <= h1;
         h3 <= h2;
      end
   end

   // Evaluated in DONE, so the newest sample is already in h0
   assign sum    = 10'(h0) + 10'(h1) + 10'(h2) + 10'(h3);
   assign result = sum[9:2];
`else
   logic [7:0] raw;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         raw <= 8'h00;
      end else if (capture) begin
         raw <= adc_d;
      end
   end

   assign result = raw;
`endif

   // Sequencer; every strobe is registered and changes on the transition edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= StGap;
         cnt          <= 10'd0;
         adc_convstn  <= 1'b1;
         adc_csn      <= 1'b1;
         adc_rdn      <= 1'b1;
         sample_data  <= 8'h00;
         sample_valid <= 1'b0;
         led_out      <= 8'h00;
         timeout_err  <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         cnt          <= cnt + 10'd1;
         case (state)
            StGap: begin
               if (cnt == GapLast) begin
                  state       <= StConvst;
                  cnt         <= 10'd0;
                  adc_csn     <= 1'b0;
                  adc_convstn <= 1'b0;
               end
            end
            StConvst: begin
               if (cnt == ConvLast) begin
                  state       <= StWaitBusy;
                  cnt         <= 10'd0;
                  adc_convstn <= 1'b1;
               end
            end
            StWaitBusy: begin
               // Early low BUSY is ignored: it may predate the rise or still be in the sync
               if ((cnt >= BusyMinLast) && !busy_s) begin
                  state   <= StRead;
                  cnt     <= 10'd0;
                  adc_rdn <= 1'b0;
               end else if (cnt == TimeoutLast) begin
                  state       <= StGap;
                  cnt         <= 10'd0;
                  adc_csn     <= 1'b1;
                  timeout_err <= 1'b1;
               end
            end
            StRead: begin
               if (cnt == RdLast) begin
                  state   <= StDone;
                  cnt     <= 10'd0;
                  adc_rdn <= 1'b1;
                  adc_csn <= 1'b1;
               end
            end
            StDone: begin
               state        <= StGap;
               cnt          <= 10'd0;
               sample_data  <= result;
               led_out      <= result;
               sample_valid <= 1'b1;
            end
            default: begin
               state       <= StGap;
               cnt         <= 10'd0;
               adc_convstn <= 1'b1;
               adc_csn     <= 1'b1;
               adc_rdn     <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_par_reader.sv
// ---------------------------------------------------------------------------------------------
// tb_adc_par_reader
//   Self-checking bench for adc_par_reader: a vector table of handshake scenarios, a mid-READ
//   reset sequence, randomized conversions against a behavioural model, and (when built with
//   ADC_AVG_EN) the four-sample averaging ramp.
// ---------------------------------------------------------------------------------------------
module tb_adc_par_reader;

   localparam int GAP_CYC      = 200;
   localparam int CONV_CYC     = 20;
   localparam int RD_CYC       = 30;
   localparam int BUSY_MIN     = 4;
   localparam int BUSY_TIMEOUT = 1000;

   localparam int SelConv  = 0;
   localparam int SelCsn   = 1;
   localparam int SelRdn   = 2;
   localparam int SelValid = 3;

   // Busy model modes
   localparam int BusyPulse  = 0;
   localparam int BusyStuck1 = 1;
   localparam int BusyStuck0 = 2;

   logic       clk;
   logic       rst;
   logic       adc_busy;
   logic [7:0] adc_d;
   logic       adc_convstn;
   logic       adc_csn;
   logic       adc_rdn;
   logic [7:0] sample_data;
   logic       sample_valid;
   logic [7:0] led_out;
   logic       timeout_err;

   int checks;
   int errors;
   int cyc;
   int busy_mode;
   int busy_len;
   int seen_valid;
   bit gap_bad;
   int gap_start;
   int gap_exp;
   bit exp_sticky;

   adc_par_reader #(
      .GAP_CYC     (GAP_CYC),
      .CONV_CYC    (CONV_CYC),
      .RD_CYC      (RD_CYC),
      .BUSY_MIN    (BUSY_MIN),
      .BUSY_TIMEOUT(BUSY_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .adc_busy    (adc_busy),
      .adc_d       (adc_d),
      .adc_convstn (adc_convstn),
      .adc_csn     (adc_csn),
      .adc_rdn     (adc_rdn),
      .sample_data (sample_data),
      .sample_valid(sample_valid),
      .led_out     (led_out),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ADC BUSY model: rises when CONVSTn returns high, stays high busy_len cycles
   initial begin
      forever begin
         @(posedge adc_convstn);
         if (busy_mode == BusyPulse) begin
            adc_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 adc_busy = 1'b0;
         end
      end
   end

   // ---------------- reference model ----------------
`ifdef ADC_AVG_EN
   logic [7:0] hist[$];
`endif

   function automatic void model_reset();
`ifdef ADC_AVG_EN
      hist.delete();
`endif
   endfunction

   function automatic logic [7:0] model_push(input logic [7:0] raw);
`ifdef ADC_AVG_EN
      int s;
      hist.push_front(raw);
      if (hist.size() > 4) void'(hist.pop_back());
      s = 0;
      foreach (hist[i]) s += int'(hist[i]);
      return 8'(s / 4);
`else
      return raw;
`endif
   endfunction

   // BUSY low is visible to the sequencer len+2 cycles after WAIT entry (two sync flops),
   // and the move to READ happens on the following edge, but never before BUSY_MIN.
   function automatic void model_busy(input int mode, input int len, output bit to,
                                      output int dly);
      case (mode)
         BusyStuck1: begin
            to  = 1'b1;
            dly = 0;
         end
         BusyStuck0: begin
            to  = 1'b0;
            dly = BUSY_MIN;
         end
         default: begin
            dly = (len + 3 > BUSY_MIN) ? len + 3 : BUSY_MIN;
            to  = (dly > BUSY_TIMEOUT);
            if (to) dly = 0;
         end
      endcase
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         SelConv: return adc_convstn;
         SelCsn:  return adc_csn;
         SelRdn:  return adc_rdn;
         default: return sample_valid;
      endcase
   endfunction

   // Steps negedge by negedge until the selected output reaches lvl (bounded)
   task automatic wait_for(input int sel, input logic lvl, input int limit, input string name,
                           output int t);
      int n;
      n = 0;
      while (sig(sel) !== lvl && n < limit) begin
         @(negedge clk);
         n++;
         if (sample_valid === 1'b1) seen_valid++;
         if (sel == SelConv && lvl == 1'b0 && adc_convstn === 1'b1 &&
             (adc_csn !== 1'b1 || adc_rdn !== 1'b1)) gap_bad = 1'b1;
      end
      check({name, " reached"}, 32'(sig(sel)), 32'(lvl));
      t = cyc;
   endtask

   // One full conversion with timing, handshake and data checks
   task automatic run_conv(input logic [7:0] d, input int mode, input int len, input bit exp_to,
                           input int exp_dly, input string tag);
      int t_cf, t_cr, t_rf, t_rr, t_cs;
      logic [7:0] exp_d;
      adc_d      = d;
      busy_mode  = mode;
      busy_len   = len;
      adc_busy   = (mode == BusyStuck1);
      seen_valid = 0;
      gap_bad    = 1'b0;
      wait_for(SelConv, 1'b0, GAP_CYC + 200, {tag, " convst fall"}, t_cf);
      if (gap_start >= 0) check({tag, " gap length"}, t_cf - gap_start, gap_exp);
      check({tag, " strobes high in gap"}, 32'(gap_bad), 0);
      check({tag, " csn low at convst"}, 32'(adc_csn), 0);
      wait_for(SelConv, 1'b1, CONV_CYC + 50, {tag, " convst rise"}, t_cr);
      check({tag, " convst low length"}, t_cr - t_cf, CONV_CYC);
      check({tag, " timeout flag before wait"}, 32'(timeout_err), 32'(exp_sticky));
      if (exp_to) begin
         wait_for(SelCsn, 1'b1, BUSY_TIMEOUT + 50, {tag, " csn rise on timeout"}, t_cs);
         check({tag, " busy timeout length"}, t_cs - t_cr, BUSY_TIMEOUT);
         check({tag, " timeout flag"}, 32'(timeout_err), 1);
         check({tag, " rdn idle on timeout"}, 32'(adc_rdn), 1);
         @(negedge clk);
         if (sample_valid === 1'b1) seen_valid++;
         check({tag, " no valid on timeout"}, seen_valid, 0);
         exp_sticky = 1'b1;
         gap_start  = t_cs;
         gap_exp    = GAP_CYC;
      end else begin
         wait_for(SelRdn, 1'b0, BUSY_TIMEOUT + 50, {tag, " rdn fall"}, t_rf);
         check({tag, " busy wait length"}, t_rf - t_cr, exp_dly);
         check({tag, " csn low in read"}, 32'(adc_csn), 0);
         wait_for(SelRdn, 1'b1, RD_CYC + 50, {tag, " rdn rise"}, t_rr);
         check({tag, " rdn low length"}, t_rr - t_rf, RD_CYC);
         check({tag, " csn high in done"}, 32'(adc_csn), 1);
         check({tag, " no early valid"}, seen_valid, 0);
         exp_d = model_push(d);
         @(negedge clk);
         check({tag, " valid pulse"}, 32'(sample_valid), 1);
         check({tag, " sample_data"}, 32'(sample_data), 32'(exp_d));
         check({tag, " led_out"}, 32'(led_out), 32'(exp_d));
         @(negedge clk);
         check({tag, " valid one cycle"}, 32'(sample_valid), 0);
         check({tag, " data held"}, 32'(sample_data), 32'(exp_d));
         gap_start = t_rr;
         gap_exp   = GAP_CYC + 1;
      end
   endtask

   // ---------------- stimulus ----------------
   typedef struct {
      logic [7:0] d;
      int         mode;
      int         len;
      bit         exp_to;
      int         exp_dly;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int dummy;
      int mode;
      int len;
      int dly;
      bit to;
      logic [7:0] d;

      vecs[0] = '{8'h5A, BusyPulse,  50,  1'b0, 53};
      vecs[1] = '{8'h00, BusyPulse,  50,  1'b0, 53};
      vecs[2] = '{8'hFF, BusyPulse,  50,  1'b0, 53};
      vecs[3] = '{8'hA5, BusyStuck1, 0,   1'b1, 0};
      vecs[4] = '{8'h3C, BusyPulse,  1,   1'b0, 4};
      vecs[5] = '{8'hC3, BusyStuck0, 0,   1'b0, 4};
      vecs[6] = '{8'h81, BusyPulse,  997, 1'b0, 1000};
      vecs[7] = '{8'h7E, BusyPulse,  998, 1'b1, 0};
      vecs[8] = '{8'h96, BusyPulse,  10,  1'b0, 13};

      checks     = 0;
      errors     = 0;
      cyc        = 0;
      rst        = 1'b0;
      adc_busy   = 1'b0;
      adc_d      = 8'h00;
      busy_mode  = BusyStuck0;
      busy_len   = 0;
      seen_valid = 0;
      gap_bad    = 1'b0;
      gap_start  = -1;
      gap_exp    = GAP_CYC;
      exp_sticky = 1'b0;
      model_reset();

      repeat (3) @(negedge clk);
      check("reset convstn", 32'(adc_convstn), 1);
      check("reset csn", 32'(adc_csn), 1);
      check("reset rdn", 32'(adc_rdn), 1);
      check("reset valid", 32'(sample_valid), 0);
      check("reset data", 32'(sample_data), 0);
      check("reset led", 32'(led_out), 0);
      check("reset timeout", 32'(timeout_err), 0);
      rst       = 1'b1;
      gap_start = cyc;
      gap_exp   = GAP_CYC;

      // Vector table: handshake corners incl. BUSY exactly at the timeout boundary
      for (int i = 0; i < 9; i++) begin
         run_conv(vecs[i].d, vecs[i].mode, vecs[i].len, vecs[i].exp_to, vecs[i].exp_dly,
                  $sformatf("vec%0d", i));
      end

      // Reset in the middle of READ: strobes release at once, nothing is delivered
      adc_d     = 8'h99;
      busy_mode = BusyPulse;
      busy_len  = 20;
      adc_busy  = 1'b0;
      wait_for(SelConv, 1'b0, GAP_CYC + 200, "rstmid convst fall", dummy);
      wait_for(SelRdn, 1'b0, BUSY_TIMEOUT + 50, "rstmid rdn fall", dummy);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmid rdn released", 32'(adc_rdn), 1);
      check("rstmid csn released", 32'(adc_csn), 1);
      check("rstmid convstn", 32'(adc_convstn), 1);
      check("rstmid valid", 32'(sample_valid), 0);
      check("rstmid data cleared", 32'(sample_data), 0);
      check("rstmid timeout cleared", 32'(timeout_err), 0);
      model_reset();
      exp_sticky = 1'b0;
      repeat (3) @(negedge clk);
      check("rstmid valid during reset", 32'(sample_valid), 0);
      rst       = 1'b1;
      gap_start = cyc;
      gap_exp   = GAP_CYC;

      // Randomized conversions against the model
      for (int i = 0; i < 8; i++) begin
         d    = 8'($urandom);
         mode = ($urandom_range(0, 9) < 7) ? BusyPulse :
                (($urandom_range(0, 1) == 0) ? BusyStuck0 : BusyStuck1);
         len  = $urandom_range(1, 80);
         model_busy(mode, len, to, dly);
         run_conv(d, mode, len, to, dly, $sformatf("rnd%0d", i));
      end

`ifdef ADC_AVG_EN
      begin
         logic [7:0] t6_in[4];
         logic [7:0] t6_exp[4];
         t6_in  = '{8'h10, 8'h20, 8'h30, 8'h40};
         t6_exp = '{8'h04, 8'h0C, 8'h18, 8'h28};
         rst = 1'b0;
         @(negedge clk);
         model_reset();
         exp_sticky = 1'b0;
         rst        = 1'b1;
         gap_start  = cyc;
         gap_exp    = GAP_CYC;
         for (int i = 0; i < 4; i++) begin
            run_conv(t6_in[i], BusyStuck0, 0, 1'b0, BUSY_MIN, $sformatf("avg%0d", i));
            check($sformatf("avg%0d ramp value", i), 32'(sample_data), 32'(t6_exp[i]));
         end
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
